regf_dbg_ctrl: RTL and testbench

Debug access controller for the integer register file inside `risc_top`. It halts the core, waits for the pipeline to drain, and performs one 64-bit register read or write through the register file's shared write/read port. It then resumes the core. Benches and a future debug module use it to check architectural state without hierarchical peeks into the register file.

---
 rtl/regf_dbg_ctrl.sv | 124 ++++++++++++
 tb/tb_regf_dbg_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regf_dbg_ctrl.sv
// Debug access controller for the core register file: halts the core, waits for
// the pipeline to drain, performs one read or write, then releases the core.
module regf_dbg_ctrl #(
  parameter int XLEN          = 64,
  parameter int AW            = 5,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic            dbg_err,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            dbg_busy,
  output logic            core_halt_req,
  input  logic            core_pipe_empty,
  input  logic            core_rf_we,
  input  logic [AW-1:0]   core_rf_waddr,
  input  logic [XLEN-1:0] core_rf_wdata,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata
);

  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HALT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic [CW-1:0]   r_cnt;
  logic            r_err;

  logic w_accept;
  logic w_timeout;
  logic w_collide;
  logic w_dbgWr;

  assign w_accept  = (r_state == S_IDLE) && dbg_req;
  // The drain bound is checked only on a not-empty edge, so an empty pipe wins a tie.
  assign w_timeout = (r_state == S_HALT) && !core_pipe_empty && (r_cnt == CW'(DRAIN_TIMEOUT));
  assign w_collide = (r_state == S_ACCESS) && core_rf_we;
  assign w_dbgWr   = (r_state == S_ACCESS) && !core_rf_we && r_we && (r_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (dbg_req) w_next = S_HALT;
      S_HALT: begin
        if (core_pipe_empty) w_next = S_ACCESS;
        else if (w_timeout)  w_next = S_RESP;
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= dbg_we;
        r_addr  <= dbg_addr;
        r_wdata <= dbg_wdata;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end
      if ((r_state == S_HALT) && !core_pipe_empty) begin
        if (w_timeout) r_err <= 1'b1;
        else           r_cnt <= r_cnt + CW'(1);
      end
      if (w_collide) r_err <= 1'b1;
      if ((r_state == S_ACCESS) && !r_we)
        r_rdata <= (r_addr == '0) ? '0 : rf_rdata;
    end
  end

  // A core writeback always owns the port; the debug write only goes out when it is idle.
  always_comb begin
    rf_we    = core_rf_we;
    rf_waddr = core_rf_waddr;
    rf_wdata = core_rf_wdata;
    rf_raddr = '0;
    if (w_dbgWr) begin
      rf_we    = 1'b1;
      rf_waddr = r_addr;
      rf_wdata = r_wdata;
    end
    if (r_state == S_ACCESS) rf_raddr = r_addr;
  end

  assign dbg_ack       = (r_state == S_RESP);
  assign dbg_err       = (r_state == S_RESP) && r_err;
  assign dbg_busy      = (r_state != S_IDLE);
  assign core_halt_req = (r_state != S_IDLE);
  assign dbg_rdata     = r_rdata;

endmodule

// File: tb/tb_regf_dbg_ctrl.sv
// Scoreboard bench for regf_dbg_ctrl: a transaction-level register file model
// predicts ack timing, error flag and read data for randomized debug accesses.
module tb_regf_dbg_ctrl;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int T    = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            dbg_req = 1'b0;
  logic            dbg_we = 1'b0;
  logic [AW-1:0]   dbg_addr = '0;
  logic [XLEN-1:0] dbg_wdata = '0;
  logic            dbg_ack;
  logic            dbg_err;
  logic [XLEN-1:0] dbg_rdata;
  logic            dbg_busy;
  logic            core_halt_req;
  logic            core_pipe_empty = 1'b1;
  logic            core_rf_we = 1'b0;
  logic [AW-1:0]   core_rf_waddr = '0;
  logic [XLEN-1:0] core_rf_wdata = '0;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   rf_raddr;
  logic [XLEN-1:0] rf_rdata;

  regf_dbg_ctrl #(.XLEN(XLEN), .AW(AW), .DRAIN_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata), .dbg_busy(dbg_busy),
    .core_halt_req(core_halt_req), .core_pipe_empty(core_pipe_empty),
    .core_rf_we(core_rf_we), .core_rf_waddr(core_rf_waddr), .core_rf_wdata(core_rf_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  // Register file the controller sits in front of; x0 is hardwired to zero.
  logic [XLEN-1:0] envRf [32];
  always @(posedge clk) if (rf_we && rf_waddr != '0) envRf[rf_waddr] <= rf_wdata;
  assign rf_rdata = (rf_raddr == '0) ? '0 : envRf[rf_raddr];

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  typedef struct {
    int              endCycle;
    logic            err;
    logic [XLEN-1:0] rdata;
    int              lat;
  } exp_t;

  exp_t            sbq[$];
  logic [XLEN-1:0] golden [32];
  logic [XLEN-1:0] lastRead = '0;
  int              checks = 0;
  int              errors = 0;
  int              haltCnt = 0;
  int              x0Writes = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        haltCnt = 0;
      end else begin
        checkOutput("busy_eq_halt", 64'(dbg_busy), 64'(core_halt_req));
        if (core_halt_req) haltCnt++;
        else haltCnt = 0;
        if (rf_we && rf_waddr == '0 && !core_rf_we) x0Writes++;
        if (dbg_ack) begin
          if (sbq.size() == 0) begin
            checkOutput("unexpected_ack", 64'(1), 64'(0));
          end else begin
            exp_t e = sbq.pop_front();
            checkOutput("ack_cycle", 64'(cycleCnt), 64'(e.endCycle));
            checkOutput("ack_err", 64'(dbg_err), 64'(e.err));
            checkOutput("ack_rdata", dbg_rdata, e.rdata);
            checkOutput("halt_span", 64'(haltCnt), 64'(e.lat));
          end
        end
      end
    end
  endtask

  // One debug access; d is the number of not-empty drain edges after the request edge.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [XLEN-1:0] wdata,
                               input int d, input logic collide,
                               input logic [AW-1:0] cAddr, input logic [XLEN-1:0] cData);
    logic            cwWe   [T+2];
    logic [AW-1:0]   cwAddr [T+2];
    logic [XLEN-1:0] cwData [T+2];
    logic            timeout;
    int              nDrain;
    logic            seen;
    exp_t            e;
    for (int i = 0; i < T + 2; i++) begin
      cwWe[i]   = 1'($urandom_range(0, 1));
      cwAddr[i] = AW'($urandom);
      cwData[i] = {$urandom, $urandom};
    end
    timeout = (d >= T + 1);
    nDrain  = timeout ? T + 1 : d;
    for (int i = 1; i <= nDrain; i++)
      if (cwWe[i] && cwAddr[i] != '0) golden[cwAddr[i]] = cwData[i];
    if (!timeout) begin
      if (we) begin
        if (collide) begin
          if (cAddr != '0) golden[cAddr] = cData;
        end else if (addr != '0) begin
          golden[addr] = wdata;
        end
      end else begin
        lastRead = (addr == '0) ? '0 : golden[addr];
      end
    end
    e.err      = timeout || collide;
    e.rdata    = lastRead;
    e.lat      = timeout ? T + 2 : d + 3;
    e.endCycle = cycleCnt + e.lat;
    sbq.push_back(e);

    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    core_rf_we = 1'b0;
    @(posedge clk); #1;
    dbg_req = 1'b0; dbg_we = 1'($urandom); dbg_addr = AW'($urandom); dbg_wdata = {$urandom, $urandom};
    seen = 1'b0;
    for (int i = 1; i <= T + 6 && !seen; i++) begin
      core_pipe_empty = (i > d);
      core_rf_we = 1'b0;
      if (i <= nDrain && cwWe[i]) begin
        core_rf_we = 1'b1; core_rf_waddr = cwAddr[i]; core_rf_wdata = cwData[i];
      end
      if (collide && i == d + 2) begin
        core_rf_we = 1'b1; core_rf_waddr = cAddr; core_rf_wdata = cData;
      end
      if (i <= nDrain && cwWe[i]) begin
        #1;
        checkOutput("drain_pass_we", 64'(rf_we), 64'(1));
        checkOutput("drain_pass_addr", 64'(rf_waddr), 64'(cwAddr[i]));
        checkOutput("drain_pass_data", rf_wdata, cwData[i]);
      end
      @(posedge clk); #1;
      if (dbg_ack) seen = 1'b1;
    end
    if (!seen) checkOutput("ack_wait_expired", 64'(0), 64'(1));
    core_rf_we = 1'b0;
    core_pipe_empty = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    fork
      monitor();
    join_none

    #1 rst = 1'b1;
    #1;
    checkOutput("rst_ack", 64'(dbg_ack), 64'(0));
    checkOutput("rst_err", 64'(dbg_err), 64'(0));
    checkOutput("rst_busy", 64'(dbg_busy), 64'(0));
    checkOutput("rst_halt", 64'(core_halt_req), 64'(0));
    checkOutput("rst_rdata", dbg_rdata, 64'(0));
    checkOutput("rst_raddr", 64'(rf_raddr), 64'(0));
    golden[0] = '0;
    // Preload the register file through the pass-through port while held in reset.
    for (int r = 1; r < 32; r++) begin
      core_rf_we = 1'b1; core_rf_waddr = AW'(r); core_rf_wdata = {$urandom, $urandom};
      golden[r] = core_rf_wdata;
      #1;
      checkOutput("rst_pass_we", 64'(rf_we), 64'(1));
      checkOutput("rst_pass_addr", 64'(rf_waddr), 64'(r));
      checkOutput("rst_pass_data", rf_wdata, core_rf_wdata);
      @(posedge clk); #1;
    end
    core_rf_we = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    core_rf_we = 1'b1; core_rf_waddr = 5'd6; core_rf_wdata = 64'd10; golden[6] = 64'd10;
    @(posedge clk); #1;
    core_rf_we = 1'b0;

    applyStimulus(1'b0, 5'd6, '0, 0, 1'b0, '0, '0);
    applyStimulus(1'b1, 5'd9, 64'hDEAD_BEEF, 0, 1'b0, '0, '0);
    applyStimulus(1'b0, 5'd9, '0, 0, 1'b0, '0, '0);
    applyStimulus(1'b1, 5'd0, 64'd5, 0, 1'b0, '0, '0);
    applyStimulus(1'b0, 5'd0, '0, 0, 1'b0, '0, '0);
    applyStimulus(1'b0, 5'd13, '0, 4, 1'b0, '0, '0);
    applyStimulus(1'b1, 5'd12, 64'h1234_5678_9ABC_DEF0, T + 5, 1'b0, '0, '0);
    applyStimulus(1'b0, 5'd12, '0, T + 1, 1'b0, '0, '0);
    applyStimulus(1'b0, 5'd12, '0, T, 1'b0, '0, '0);
    applyStimulus(1'b1, 5'd7, 64'd1, 0, 1'b1, 5'd7, 64'd36);
    applyStimulus(1'b0, 5'd7, '0, 0, 1'b0, '0, '0);

    // Reset pulsed while waiting for the drain: the in-flight write must be abandoned.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = {$urandom, $urandom};
    core_pipe_empty = 1'b0;
    @(posedge clk); #1;
    dbg_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(dbg_busy), 64'(0));
    checkOutput("midrst_halt", 64'(core_halt_req), 64'(0));
    checkOutput("midrst_ack", 64'(dbg_ack), 64'(0));
    @(negedge clk); #1;
    rst = 1'b0;
    lastRead = '0;
    checkOutput("midrst_rdata", dbg_rdata, 64'(0));
    core_pipe_empty = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 5'd3, '0, 0, 1'b0, '0, '0);

    for (int n = 0; n < 60; n++) begin
      logic          we;
      logic [AW-1:0] addr;
      int            d;
      we   = 1'($urandom_range(0, 1));
      addr = AW'($urandom);
      d    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T - 1, T + 2)) : int'($urandom_range(0, 5));
      applyStimulus(we, addr, {$urandom, $urandom}, d,
                    we && ($urandom_range(0, 5) == 0), AW'($urandom), {$urandom, $urandom});
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 64'(sbq.size()), 64'(0));
    checkOutput("x0_debug_writes", 64'(x0Writes), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
